// File: rtl/pc_pkg.sv
// Shared next-PC source encodings for the fetch-path
// program counter and its decoder.
package pc_pkg;

  localparam logic [2:0] SEL_INC  = 3'b000;
  localparam logic [2:0] SEL_ABS  = 3'b001;
  localparam logic [2:0] SEL_MEM  = 3'b010;
  localparam logic [2:0] SEL_REL  = 3'b011;
  localparam logic [2:0] SEL_CALL = 3'b100;
  localparam logic [2:0] SEL_RET  = 3'b101;

endpackage

// File: rtl/return_stack.sv
// Register-array LIFO holding return addresses;
// push when full and pop when empty are dropped.
module return_stack #(
  parameter  int W     = 16,
  parameter  int DEPTH = 8,
  localparam int DW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [DW-1:0] sp;
  logic [DW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (sp == DW'(DEPTH));
  assign empty   = (sp == '0);
  assign depth   = sp;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign top_idx = sp - DW'(1);
  assign dout    = mem[top_idx[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + DW'(1);
    end else if (do_pop) begin
      sp <= sp - DW'(1);
    end
  end

  // Contents survive reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[sp[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with jump/branch sources and a
// hardware return-address stack for CALL/RET.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter  int              PC_W     = 16,
  parameter  int              MADDR_W  = 10,
  parameter  int              DEPTH    = 8,
  parameter  logic [PC_W-1:0] RESET_PC = '0,
  localparam int              DW       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_en,
  input  logic [2:0]         sel,
  input  logic [PC_W-1:0]    imm,
  input  logic [MADDR_W-1:0] mem_addr,
  output logic [PC_W-1:0]    cnt,
  output logic [DW-1:0]      depth,
  output logic               stk_full,
  output logic               stk_empty,
  output logic               stk_err
);

  logic [PC_W-1:0] nxt;
  logic [PC_W-1:0] ret_addr;
  logic [PC_W-1:0] cnt_inc;
  logic            push;
  logic            pop;
  logic            err_set;

  assign cnt_inc = cnt + PC_W'(1);

  return_stack #(
    .W     (PC_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push & pc_en),
    .pop   (pop & pc_en),
    .din   (cnt_inc),
    .dout  (ret_addr),
    .depth (depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    nxt     = cnt;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    unique case (1'b1)
      sel == SEL_INC: nxt = cnt_inc;
      sel == SEL_ABS: nxt = imm;
      sel == SEL_MEM: nxt = PC_W'(mem_addr);
      sel == SEL_REL: nxt = cnt + imm;
      sel == SEL_CALL: begin
        if (stk_full) begin
          err_set = 1'b1;
        end else begin
          push = 1'b1;
          nxt  = imm;
        end
      end
      sel == SEL_RET: begin
        if (stk_empty) begin
          err_set = 1'b1;
        end else begin
          pop = 1'b1;
          nxt = ret_addr;
        end
      end
      default: nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= RESET_PC;
      stk_err <= 1'b0;
    end else if (pc_en) begin
      cnt     <= nxt;
      stk_err <= stk_err | err_set;
    end
  end

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack: directed scenarios
// followed by randomized traffic against a queue-based model.
module tb_pc_call_stack;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_en = 1'b0;
  logic [2:0]  sel = 3'b000;
  logic [15:0] imm = '0;
  logic [9:0]  mem_addr = '0;
  logic [15:0] cnt;
  logic [3:0]  depth;
  logic        stk_full;
  logic        stk_empty;
  logic        stk_err;

  pc_call_stack #(
    .PC_W     (16),
    .MADDR_W  (10),
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_en     (pc_en),
    .sel       (sel),
    .imm       (imm),
    .mem_addr  (mem_addr),
    .cnt       (cnt),
    .depth     (depth),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_err   (stk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cnt;
    int          depth;
    bit          full;
    bit          empty;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_cnt;
  logic [15:0] m_stk[$];
  bit          m_err;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.cnt   = m_cnt;
    e.depth = m_stk.size();
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    return e;
  endfunction

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".cnt"},   int'(cnt),       int'(e.cnt));
    chk({tag, ".depth"}, int'(depth),     e.depth);
    chk({tag, ".full"},  int'(stk_full),  int'(e.full));
    chk({tag, ".empty"}, int'(stk_empty), int'(e.empty));
    chk({tag, ".err"},   int'(stk_err),   int'(e.err));
  endtask

  // Reference behaviour of one enabled/disabled clock edge.
  task automatic model(input bit en, input logic [2:0] s,
                       input logic [15:0] i, input logic [9:0] ma);
    if (!en) return;
    case (s)
      3'd0: m_cnt = m_cnt + 16'd1;
      3'd1: m_cnt = i;
      3'd2: m_cnt = {6'd0, ma};
      3'd3: m_cnt = m_cnt + i;
      3'd4: begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else begin
          m_stk.push_back(m_cnt + 16'd1);
          m_cnt = i;
        end
      end
      3'd5: begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else m_cnt = m_stk.pop_back();
      end
      default: ;
    endcase
  endtask

  task automatic step(input bit en, input logic [2:0] s,
                      input logic [15:0] i, input logic [9:0] ma);
    @(negedge clk);
    pc_en = en;
    sel = s;
    imm = i;
    mem_addr = ma;
    model(en, s, i, ma);
    sb.push_back(snap());
  endtask

  // Asserted on the falling edge, checked before the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    pc_en = 1'b0;
    sb.delete();
    m_cnt = 16'h0000;
    m_stk.delete();
    m_err = 1'b0;
    #1;
    chk_all("reset", snap());
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_all("edge", e);
    end
  end

  initial begin
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 3'd0, '0, '0);
    step(1, 3'd1, 16'hFFFF, '0);
    step(1, 3'd0, '0, '0);
    step(1, 3'd1, 16'd10, '0);
    step(1, 3'd3, 16'hFFFC, '0);
    step(1, 3'd2, '0, 10'h3A5);
    step(1, 3'd1, 16'h0020, '0);
    step(1, 3'd4, 16'h0100, '0);
    step(1, 3'd4, 16'h0200, '0);
    step(1, 3'd5, '0, '0);
    step(1, 3'd5, '0, '0);
    step(1, 3'd6, 16'h1234, '0);

    do_reset();
    step(1, 3'd1, 16'h0040, '0);
    for (int k = 0; k <= DEPTH; k++)
      step(1, 3'd4, 16'h1000 + 16'(k * 16), '0);
    for (int k = 0; k < DEPTH; k++) step(1, 3'd5, '0, '0);
    step(1, 3'd0, '0, '0);

    do_reset();
    step(1, 3'd5, '0, '0);
    step(0, 3'd4, 16'h0300, '0);
    step(0, 3'd4, 16'h0400, '0);
    step(1, 3'd4, 16'h0500, '0);
    step(1, 3'd4, 16'h0600, '0);
    do_reset();

    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 9) != 0,
                3'($urandom_range(0, 7)),
                16'($urandom), 10'($urandom));
    end
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
